// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the MIPS pipeline front end.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with stall (hold) and flush (squash
//               to a nop bubble). Flush overrides stall.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC_VAL = mips_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_pc4,
  input  logic [31:0] fetch_instr,
  input  logic        fetch_oor,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        if_id_oor
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        oor_q, oor_d;

  // Next-state selection: flush bubble, stall hold, or normal capture.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    oor_d   = oor_q;
    if (flush) begin
      instr_d = NOP_INSTR;
      pc_d    = fetch_pc;
      pc4_d   = fetch_pc4;
      valid_d = 1'b0;
      oor_d   = 1'b0;
    end else if (!stall) begin
      instr_d = fetch_instr;
      pc_d    = fetch_pc;
      pc4_d   = fetch_pc4;
      valid_d = 1'b1;
      oor_d   = fetch_oor;
    end
  end

  // Register bank with asynchronous reset to an empty nop slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_INSTR;
      pc_q    <= RESET_PC_VAL;
      pc4_q   <= RESET_PC_VAL + WORD_BYTES;
      valid_q <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      oor_q   <= oor_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign if_id_oor   = oor_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : IF stage - program counter, instruction memory addressing and
//               IF/ID capture with stall, redirect and flush handling.
//               Optional macro IF_PERF_CNT_EN adds fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_instr,
  output logic [31:0]      pc,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      stall_cnt,
`endif
  output logic             if_id_oor
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic        oor_now;
  logic [31:0] fetch_instr;

  assign pc_plus4 = pc_q + WORD_BYTES;
  assign im_addr  = pc_q[IM_AW+1:2];
  assign pc       = pc_q;

  // Out-of-range: misaligned, or upper bits leave the window RESET_PC sits in.
  assign oor_now = (pc_q[1:0] != 2'b00) ||
                   (pc_q[31:IM_AW+2] != RESET_PC[31:IM_AW+2]);

  // An out-of-range fetch is replaced by a nop so garbage never reaches ID.
  assign fetch_instr = oor_now ? NOP_INSTR : im_instr;

  // Next-PC priority: flush, redirect (even under stall), stall, sequential.
  always_comb begin
    pc_d = pc_plus4;
    if (flush) begin
      pc_d = pc_plus4;
    end else if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  if_id_reg #(
    .RESET_PC_VAL (RESET_PC)
  ) u_if_id_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .fetch_pc    (pc_q),
    .fetch_pc4   (pc_plus4),
    .fetch_instr (fetch_instr),
    .fetch_oor   (oor_now),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .if_id_oor   (if_id_oor)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count valid IF/ID loads and stalled (non-flushed) cycles; both wrap.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (!flush && !stall) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (stall && !flush) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit with a
//               combinational instruction-memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  im_addr;
  logic [31:0] im_instr;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        if_id_oor;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  logic [31:0] imem [0:1023];
  int total;
  int bad;

  assign im_instr = imem[im_addr];

  if_fetch_unit #(
    .RESET_PC (32'h0000_3000),
    .IM_AW    (10)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .im_addr        (im_addr),
    .im_instr       (im_instr),
    .pc             (pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc4      (if_id_pc4),
    .if_id_valid    (if_id_valid),
`ifdef IF_PERF_CNT_EN
    .fetch_cnt      (fetch_cnt),
    .stall_cnt      (stall_cnt),
`endif
    .if_id_oor      (if_id_oor)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h3000); end
    total++; if (im_addr !== 10'd0) begin bad++; $display("FAIL rst_im_addr got=%h exp=%h", im_addr, 10'd0); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr, 32'h0); end
    total++; if (if_id_pc !== 32'h3000) begin bad++; $display("FAIL rst_if_id_pc got=%h exp=%h", if_id_pc, 32'h3000); end
    total++; if (if_id_pc4 !== 32'h3004) begin bad++; $display("FAIL rst_if_id_pc4 got=%h exp=%h", if_id_pc4, 32'h3004); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_oor !== 1'b0) begin bad++; $display("FAIL rst_oor got=%b exp=0", if_id_oor); end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [31:0] exp_pc [0:2];
    logic [31:0] exp_in [0:2];
    exp_pc[0] = 32'h3004; exp_pc[1] = 32'h3008;
    exp_in[0] = 32'h11;   exp_in[1] = 32'h22;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (pc !== exp_pc[i]) begin bad++; $display("FAIL free_pc[%0d] got=%h exp=%h", i, pc, exp_pc[i]); end
      total++; if (if_id_instr !== exp_in[i]) begin bad++; $display("FAIL free_instr[%0d] got=%h exp=%h", i, if_id_instr, exp_in[i]); end
      total++; if (if_id_pc !== exp_pc[i] - 32'd4) begin bad++; $display("FAIL free_if_id_pc[%0d] got=%h exp=%h", i, if_id_pc, exp_pc[i] - 32'd4); end
      total++; if (if_id_pc4 !== exp_pc[i]) begin bad++; $display("FAIL free_if_id_pc4[%0d] got=%h exp=%h", i, if_id_pc4, exp_pc[i]); end
      total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL free_valid[%0d] got=%b exp=1", i, if_id_valid); end
    end
    total++; if (im_addr !== 10'd2) begin bad++; $display("FAIL free_im_addr got=%h exp=%h", im_addr, 10'd2); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (pc !== 32'h3008) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, 32'h3008); end
      total++; if (if_id_instr !== 32'h22) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, if_id_instr, 32'h22); end
      total++; if (if_id_pc !== 32'h3004) begin bad++; $display("FAIL stall_if_id_pc[%0d] got=%h exp=%h", i, if_id_pc, 32'h3004); end
      total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, if_id_valid); end
    end
    stall = 1'b0;
    step();
    total++; if (pc !== 32'h300C) begin bad++; $display("FAIL resume_pc got=%h exp=%h", pc, 32'h300C); end
    total++; if (if_id_instr !== 32'h33) begin bad++; $display("FAIL resume_instr got=%h exp=%h", if_id_instr, 32'h33); end
    total++; if (if_id_pc !== 32'h3008) begin bad++; $display("FAIL resume_if_id_pc got=%h exp=%h", if_id_pc, 32'h3008); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h3040;
    step();
    total++; if (pc !== 32'h3040) begin bad++; $display("FAIL rdst_pc got=%h exp=%h", pc, 32'h3040); end
    total++; if (if_id_instr !== 32'h33) begin bad++; $display("FAIL rdst_instr got=%h exp=%h", if_id_instr, 32'h33); end
    total++; if (if_id_pc !== 32'h3008) begin bad++; $display("FAIL rdst_if_id_pc got=%h exp=%h", if_id_pc, 32'h3008); end
    total++; if (im_addr !== 10'd16) begin bad++; $display("FAIL rdst_im_addr got=%h exp=%h", im_addr, 10'd16); end
    stall = 1'b0;
    redirect_valid = 1'b0;
    step();
    total++; if (if_id_instr !== 32'hABCD_0016) begin bad++; $display("FAIL rd_instr got=%h exp=%h", if_id_instr, 32'hABCD_0016); end
    total++; if (if_id_pc !== 32'h3040) begin bad++; $display("FAIL rd_if_id_pc got=%h exp=%h", if_id_pc, 32'h3040); end
    total++; if (if_id_pc4 !== 32'h3044) begin bad++; $display("FAIL rd_if_id_pc4 got=%h exp=%h", if_id_pc4, 32'h3044); end
    total++; if (pc !== 32'h3044) begin bad++; $display("FAIL rd_pc got=%h exp=%h", pc, 32'h3044); end
  endtask

  task automatic test_flush_stall();
    flush = 1'b1;
    stall = 1'b1;
    step();
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL flush_instr got=%h exp=%h", if_id_instr, 32'h0); end
    total++; if (if_id_pc !== 32'h3044) begin bad++; $display("FAIL flush_if_id_pc got=%h exp=%h", if_id_pc, 32'h3044); end
    total++; if (if_id_pc4 !== 32'h3048) begin bad++; $display("FAIL flush_if_id_pc4 got=%h exp=%h", if_id_pc4, 32'h3048); end
    total++; if (pc !== 32'h3048) begin bad++; $display("FAIL flush_pc got=%h exp=%h", pc, 32'h3048); end
    flush = 1'b0;
    stall = 1'b0;
    step();
    total++; if (if_id_instr !== 32'h1012) begin bad++; $display("FAIL postflush_instr got=%h exp=%h", if_id_instr, 32'h1012); end
    total++; if (if_id_valid !== 1'b1) begin bad++; $display("FAIL postflush_valid got=%b exp=1", if_id_valid); end
  endtask

  task automatic test_oor();
    // Window exit: 0x5000 maps to word 0 but must fetch a nop with oor set.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_5000;
    step();
    total++; if (pc !== 32'h5000) begin bad++; $display("FAIL oor_pc got=%h exp=%h", pc, 32'h5000); end
    total++; if (if_id_oor !== 1'b0) begin bad++; $display("FAIL oor_pre got=%b exp=0", if_id_oor); end
    redirect_valid = 1'b0;
    step();
    total++; if (if_id_oor !== 1'b1) begin bad++; $display("FAIL oor_window got=%b exp=1", if_id_oor); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL oor_window_instr got=%h exp=%h", if_id_instr, 32'h0); end
    total++; if (if_id_pc !== 32'h5000) begin bad++; $display("FAIL oor_window_pc got=%h exp=%h", if_id_pc, 32'h5000); end
    // Misaligned target in the window.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3002;
    step();
    total++; if (pc !== 32'h3002) begin bad++; $display("FAIL mis_pc got=%h exp=%h", pc, 32'h3002); end
    redirect_valid = 1'b0;
    step();
    total++; if (if_id_oor !== 1'b1) begin bad++; $display("FAIL mis_oor got=%b exp=1", if_id_oor); end
    total++; if (if_id_instr !== 32'h0) begin bad++; $display("FAIL mis_instr got=%h exp=%h", if_id_instr, 32'h0); end
    total++; if (pc !== 32'h3006) begin bad++; $display("FAIL mis_next_pc got=%h exp=%h", pc, 32'h3006); end
    // Back in range: oor clears.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    step();
    total++; if (if_id_oor !== 1'b0) begin bad++; $display("FAIL inrange_oor got=%b exp=0", if_id_oor); end
    total++; if (if_id_instr !== 32'h11) begin bad++; $display("FAIL inrange_instr got=%h exp=%h", if_id_instr, 32'h11); end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (if_id_pc4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=%h", if_id_pc4, 32'h0); end
    total++; if (if_id_oor !== 1'b1) begin bad++; $display("FAIL wrap_oor got=%b exp=1", if_id_oor); end
  endtask

  task automatic test_mid_reset();
    rst_n = 1'b0;
    #1;
    total++; if (pc !== 32'h3000) begin bad++; $display("FAIL midrst_pc got=%h exp=%h", pc, 32'h3000); end
    total++; if (if_id_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", if_id_valid); end
    total++; if (if_id_pc !== 32'h3000) begin bad++; $display("FAIL midrst_if_id_pc got=%h exp=%h", if_id_pc, 32'h3000); end
    step();
    rst_n = 1'b1;
    step();
    total++; if (pc !== 32'h3004) begin bad++; $display("FAIL midrst_first_pc got=%h exp=%h", pc, 32'h3004); end
    total++; if (if_id_instr !== 32'h11) begin bad++; $display("FAIL midrst_first_instr got=%h exp=%h", if_id_instr, 32'h11); end
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf_cnt();
    rst_n = 1'b0;
    #1;
    total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL perf_rst_fetch got=%0d exp=0", fetch_cnt); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    stall = 1'b0;
    total++; if (fetch_cnt !== 32'd10) begin bad++; $display("FAIL perf_fetch got=%0d exp=10", fetch_cnt); end
    total++; if (stall_cnt !== 32'd3) begin bad++; $display("FAIL perf_stall got=%0d exp=3", stall_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (fetch_cnt !== 32'd0) begin bad++; $display("FAIL perf_midrst_fetch got=%0d exp=0", fetch_cnt); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_midrst_stall got=%0d exp=0", stall_cnt); end
    step();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 1024; i++) imem[i] = 32'h1000 + i;
    imem[0]  = 32'h11;
    imem[1]  = 32'h22;
    imem[2]  = 32'h33;
    imem[3]  = 32'h44;
    imem[16] = 32'hABCD_0016;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_flush_stall();
    test_oor();
    test_wrap();
    test_mid_reset();
`ifdef IF_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_fetch_unit
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the program counter (PC), drives the word address into the 1024×32 instruction memory, and captures the returned instruction into the IF/ID pipeline register.
- Handles ID-stage stall, branch/jump redirect and exception flush.
- Sits between hazard/branch logic in ID (upstream control) and the decoder (downstream consumer).

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset; its bits [11:2] must be 0.
- IM_AW, 10, instruction memory word-address width (IM window = 2^IM_AW words).

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- stall, input, 1, from the hazard unit; holds the PC and IF/ID.
- flush, input, 1, from exception logic; squashes IF/ID.
- redirect_valid, input, 1, branch/jump taken; resolved in ID.
- redirect_pc, input, 32, target PC.
- im_addr, output, IM_AW, word address to the instruction memory (pc[IM_AW+1:2]).
- im_instr, input, 32, combinational read data from the instruction memory.
- pc, output, 32, current fetch PC.
- if_id_instr, output, 32, IF/ID instruction.
- if_id_pc, output, 32, PC of the IF/ID instruction.
- if_id_pc4, output, 32, if_id_pc + 4.
- if_id_valid, output, 1, IF/ID holds a real fetched instruction.
- if_id_oor, output, 1, fetched PC lay outside the IM window or was misaligned.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc = RESET_PC.
  - if_id_instr = 32'h0 (nop).
  - if_id_pc = RESET_PC; if_id_pc4 = RESET_PC+4.
  - if_id_valid = 0; if_id_oor = 0.
- Reset deassertion mid-stream: the first fetch is at RESET_PC on the next rising edge.
- im_addr = pc[IM_AW+1:2], combinational, zero latency. The IM read is combinational, so im_instr is valid in the same cycle.
- PC update per rising edge, in priority order:
  1. flush=1: pc <= pc+4.
  2. redirect_valid=1: pc <= redirect_pc. This applies even if stall=1. The branch delay slot is already in IF/ID or being fetched, so there is no squash.
  3. stall=1: pc holds.
  4. Otherwise: pc <= pc+4.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0, with no error beyond the oor flag.
- IF/ID update per rising edge:
  - flush=1: instr <= 0, valid <= 0, oor <= 0; pc/pc4 fields load the current pc/pc+4. Flush overrides stall.
  - Else stall=1: all IF/ID fields hold.
  - Else: instr <= im_instr, pc <= pc, pc4 <= pc+4, valid <= 1, oor <= oor_now.
- oor_now = (pc[1:0] != 0) or (pc[31:IM_AW+2] != RESET_PC[31:IM_AW+2]).
  - When oor_now=1, IF/ID captures instr = 0 (nop) rather than im_instr.
  - if_id_oor is informational; no trap is raised here.
- Simultaneous stall+redirect: the PC takes the redirect and IF/ID holds. The instruction fetched at the old PC is discarded.
- redirect_pc misaligned: the PC loads it as-is; the resulting fetch reports oor.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds output ports fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0.
  - fetch_cnt increments on every cycle IF/ID loads with valid=1.
  - stall_cnt increments on every cycle with stall=1 and flush=0.
  - Both wrap at 2^32.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - RESET_PC default;
  - NOP_INSTR = 32'h0;
  - a word-size constant (4).
- One natural sub-module: if_id_reg, the IF/ID pipeline register with stall/flush and its reset values.
- PC and next-PC logic stay in if_fetch_unit.

Test Plan:
- Reset release, then 4 free cycles with IM[0..3] = 32'h11,22,33,44: pc steps 3000→3004→3008→300C; if_id_instr follows 11,22,33 one cycle behind; if_id_valid rises 1 cycle after reset release.
- stall=1 for 2 cycles at pc=3008: pc and all IF/ID fields hold for 2 cycles, then resume with pc=300C.
- redirect_valid=1, redirect_pc=3040, same cycle as stall=1: next pc=3040 and IF/ID unchanged; next free cycle captures IM[16] with if_id_pc=3040.
- flush=1 together with stall=1: if_id_valid=0, if_id_instr=0, pc advances +4.
- redirect_pc=32'h0000_5000: next if_id_oor=1 and if_id_instr=0. redirect_pc=3002: oor=1.
- IF_PERF_CNT_EN defined: 10 free cycles and 3 stalls → fetch_cnt=10, stall_cnt=3. Assert rst_n low mid-run → both counters 0 immediately.
